// File: rtl/fact_pkg.sv
// Shared definitions for the factorial accelerator MMIO host: register map,
// register bit positions and the host FSM state encoding.
package fact_pkg;

    localparam logic [1:0] FACT_N    = 2'd0;
    localparam logic [1:0] FACT_CTRL = 2'd1;
    localparam logic [1:0] FACT_STAT = 2'd2;
    localparam logic [1:0] FACT_RES  = 2'd3;

    localparam int CTRL_GO = 0;
    localparam int CTRL_IE = 1;

    localparam int STAT_DONE = 0;
    localparam int STAT_ERR  = 1;
    localparam int STAT_TOUT = 2;
    localparam int STAT_OVR  = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_CAPTURE = 2'd3
    } fact_state_e;

endpackage

// File: rtl/fact_mmio_host_if.sv
// CPU data-bus slave signals plus the accelerator n/go/done/err/nf handshake,
// seen from the bus/accelerator side (master) and from the host (slave).
interface fact_mmio_host_if #(
    parameter int WIDTH = 32
);
    logic             we;
    logic [1:0]       addr;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] rd;
    logic [WIDTH-1:0] fact_n;
    logic             fact_go;
    logic             fact_done;
    logic             fact_err;
    logic [WIDTH-1:0] fact_nf;

    modport master (
        output we, addr, wd, fact_done, fact_err, fact_nf,
        input  rd, fact_n, fact_go
    );

    modport slave (
        input  we, addr, wd, fact_done, fact_err, fact_nf,
        output rd, fact_n, fact_go
    );

endinterface

// File: rtl/fact_mmio_fsm.sv
// Run sequencer: issues the go pulse, waits for a fresh done/err with a
// bounded timeout, and reports completion as single-cycle set pulses.
module fact_mmio_fsm
    import fact_pkg::*;
#(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic launch,
    input  logic fact_done,
    input  logic fact_err,
    output logic fact_go,
    output logic busy,
    output logic set_done,
    output logic set_err,
    output logic set_tout,
    output logic cap_res
);

    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    fact_state_e   state_q, state_d;
    logic          armed_q, armed_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          go_q, go_d;
    logic          busy_q, busy_d;

    always_comb begin
        state_d  = state_q;
        armed_d  = armed_q;
        cnt_d    = cnt_q;
        set_done = 1'b0;
        set_err  = 1'b0;
        set_tout = 1'b0;
        cap_res  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (launch) state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                armed_d = 1'b0;
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // A done/err level only counts after it has been seen low once.
                if (armed_q && fact_err) begin
                    set_err = 1'b1;
                    state_d = ST_CAPTURE;
                end else if (armed_q && fact_done) begin
                    set_done = 1'b1;
                    cap_res  = 1'b1;
                    state_d  = ST_CAPTURE;
                end else if (cnt_q == CNT_LAST) begin
                    set_tout = 1'b1;
                    state_d  = ST_CAPTURE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if (!(fact_done || fact_err)) armed_d = 1'b1;
                end
            end
            ST_CAPTURE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        go_d   = (state_d == ST_ISSUE);
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            armed_q <= 1'b0;
            cnt_q   <= '0;
            go_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            armed_q <= armed_d;
            cnt_q   <= cnt_d;
            go_q    <= go_d;
            busy_q  <= busy_d;
        end
    end

    assign fact_go = go_q;
    assign busy    = busy_q;

endmodule

// File: rtl/fact_mmio_host.sv
// Memory-mapped host for the factorial accelerator: N/CTRL/STATUS/RESULT
// registers, sticky W1C status, interrupt and the run sequencer.
module fact_mmio_host
    import fact_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    fact_mmio_host_if.slave        bus,
    output logic                   irq,
    output logic                   busy
);

    logic go_wr, launch, stat_wr;
    logic fsm_go, fsm_busy;
    logic set_done, set_err, set_tout, cap_res;

    logic [WIDTH-1:0] n_q, n_d;
    logic [WIDTH-1:0] n_lat_q, n_lat_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             ie_q, ie_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             tout_q, tout_d;
    logic             ovr_q, ovr_d;
    logic             irq_q, irq_d;
    logic [WIDTH-1:0] rd_mux;

    assign go_wr   = bus.we && (bus.addr == FACT_CTRL) && bus.wd[CTRL_GO];
    assign launch  = go_wr && !fsm_busy;
    assign stat_wr = bus.we && (bus.addr == FACT_STAT);

    fact_mmio_fsm #(
        .TIMEOUT (TIMEOUT)
    ) u_fsm (
        .clk       (clk),
        .rst       (rst),
        .launch    (launch),
        .fact_done (bus.fact_done),
        .fact_err  (bus.fact_err),
        .fact_go   (fsm_go),
        .busy      (fsm_busy),
        .set_done  (set_done),
        .set_err   (set_err),
        .set_tout  (set_tout),
        .cap_res   (cap_res)
    );

    always_comb begin
        n_d     = n_q;
        n_lat_d = n_lat_q;
        res_d   = res_q;
        ie_d    = ie_q;
        done_d  = done_q;
        err_d   = err_q;
        tout_d  = tout_q;
        ovr_d   = ovr_q;
        if (bus.we && (bus.addr == FACT_N)) n_d = bus.wd;
        if (bus.we && (bus.addr == FACT_CTRL)) ie_d = bus.wd[CTRL_IE];
        if (launch) n_lat_d = n_q;
        if (cap_res) res_d = bus.fact_nf;
        // Clears are applied first so a same-cycle hardware set wins.
        if (stat_wr) begin
            if (bus.wd[STAT_DONE]) done_d = 1'b0;
            if (bus.wd[STAT_ERR])  err_d  = 1'b0;
            if (bus.wd[STAT_TOUT]) tout_d = 1'b0;
            if (bus.wd[STAT_OVR])  ovr_d  = 1'b0;
        end
        if (launch) begin
            done_d = 1'b0;
            err_d  = 1'b0;
            tout_d = 1'b0;
        end
        if (set_done) done_d = 1'b1;
        if (set_err)  err_d  = 1'b1;
        if (set_tout) tout_d = 1'b1;
        if (go_wr && fsm_busy) ovr_d = 1'b1;
        irq_d = ie_q && (done_q || err_q || tout_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            n_q     <= '0;
            n_lat_q <= '0;
            res_q   <= '0;
            ie_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            tout_q  <= 1'b0;
            ovr_q   <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            n_q     <= n_d;
            n_lat_q <= n_lat_d;
            res_q   <= res_d;
            ie_q    <= ie_d;
            done_q  <= done_d;
            err_q   <= err_d;
            tout_q  <= tout_d;
            ovr_q   <= ovr_d;
            irq_q   <= irq_d;
        end
    end

    always_comb begin
        rd_mux = '0;
        case (bus.addr)
            FACT_N: rd_mux = n_q;
            FACT_CTRL: begin
                rd_mux[CTRL_GO] = fsm_busy;
                rd_mux[CTRL_IE] = ie_q;
            end
            FACT_STAT: begin
                rd_mux[STAT_DONE] = done_q;
                rd_mux[STAT_ERR]  = err_q;
                rd_mux[STAT_TOUT] = tout_q;
                rd_mux[STAT_OVR]  = ovr_q;
            end
            default: rd_mux = res_q;
        endcase
    end

    assign bus.rd      = rd_mux;
    assign bus.fact_n  = n_lat_q;
    assign bus.fact_go = fsm_go;
    assign irq         = irq_q;
    assign busy        = fsm_busy;

endmodule

// File: tb/tb_fact_mmio_host.sv
// Bench for fact_mmio_host: register table, directed run scenarios and
// randomized runs against a behavioural accelerator and expectation model.
module tb_fact_mmio_host;
    import fact_pkg::*;

    localparam int WIDTH   = 32;
    localparam int TIMEOUT = 16;

    logic clk = 1'b0;
    logic rst;
    logic irq, busy;

    fact_mmio_host_if #(.WIDTH(WIDTH)) bus ();

    fact_mmio_host #(
        .WIDTH   (WIDTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .irq  (irq),
        .busy (busy)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Accelerator model controls
    int acc_lat    = 10;
    int acc_hold   = 0;
    bit acc_silent = 1'b0;
    int go_pulses  = 0;

    function automatic logic [31:0] fact_ref(input int n);
        logic [31:0] r;
        r = 32'd1;
        for (int i = 2; i <= n; i++) r = r * 32'(i);
        return r;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus.we   = 1'b1;
        bus.addr = a;
        bus.wd   = d;
        tick();
        bus.we   = 1'b0;
    endtask

    task automatic rd_reg(input logic [1:0] a, output logic [31:0] v);
        bus.addr = a;
        #1;
        v = bus.rd;
    endtask

    task automatic wait_idle(input int bound);
        for (int i = 0; i < bound && busy; i++) tick();
        check("wait_idle_busy", 32'(busy), 32'd0);
    endtask

    // Accelerator: on go, optionally hold the old done level, then respond
    // after acc_lat cycles with n! (n <= 12) or err+done (n > 12).
    initial begin : acc_model
        int  hold;
        int  pend;
        bit  active;
        hold   = 0;
        pend   = 0;
        active = 1'b0;
        bus.fact_done = 1'b0;
        bus.fact_err  = 1'b0;
        bus.fact_nf   = '0;
        forever begin
            tick();
            if (rst) begin
                bus.fact_done = 1'b0;
                bus.fact_err  = 1'b0;
                active        = 1'b0;
            end else if (bus.fact_go) begin
                go_pulses++;
                active = 1'b1;
                hold   = acc_hold;
                pend   = acc_lat;
                if (hold == 0) begin
                    bus.fact_done = 1'b0;
                    bus.fact_err  = 1'b0;
                end
            end else if (active) begin
                if (hold > 0) begin
                    hold--;
                    if (hold == 0) begin
                        bus.fact_done = 1'b0;
                        bus.fact_err  = 1'b0;
                    end
                end else if (!acc_silent) begin
                    pend--;
                    if (pend <= 0) begin
                        active = 1'b0;
                        if (bus.fact_n > 32'd12) begin
                            bus.fact_err  = 1'b1;
                            bus.fact_done = 1'b1;
                            bus.fact_nf   = 32'hDEAD_BEEF;
                        end else begin
                            bus.fact_done = 1'b1;
                            bus.fact_nf   = fact_ref(int'(bus.fact_n));
                        end
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        we;
        logic [1:0]  addr;
        logic [31:0] wd;
        logic [31:0] exp;
    } vec_t;

    initial begin : main
        vec_t        vt[6];
        logic [31:0] v;
        logic [31:0] exp_res;
        int          g0;

        vt[0] = '{1'b1, FACT_N,    32'hDEAD_BEEF, 32'hDEAD_BEEF};
        vt[1] = '{1'b1, FACT_CTRL, 32'hFFFF_FFFE, 32'h0000_0002};
        vt[2] = '{1'b1, FACT_CTRL, 32'h0000_0000, 32'h0000_0000};
        vt[3] = '{1'b1, FACT_RES,  32'h0000_1234, 32'h0000_0000};
        vt[4] = '{1'b1, FACT_STAT, 32'h0000_000F, 32'h0000_0000};
        vt[5] = '{1'b0, FACT_N,    32'h0000_0000, 32'hDEAD_BEEF};

        rst = 1'b1;
        bus.we = 1'b0; bus.addr = 2'd0; bus.wd = '0;
        repeat (3) tick();
        check("rst_go", 32'(bus.fact_go), 32'd0);
        check("rst_n", bus.fact_n, 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        for (int a = 0; a < 4; a++) begin
            rd_reg(2'(a), v);
            check($sformatf("rst_rd%0d", a), v, 32'd0);
        end
        rst = 1'b0;
        tick();

        // Register access table
        for (int i = 0; i < 6; i++) begin
            if (vt[i].we) wr(vt[i].addr, vt[i].wd);
            rd_reg(vt[i].addr, v);
            check($sformatf("tbl%0d", i), v, vt[i].exp);
        end

        // Normal run, N=5
        acc_lat = 10; acc_hold = 0;
        wr(FACT_N, 32'd5);
        g0 = go_pulses;
        wr(FACT_CTRL, 32'd1);
        check("t1_go_hi", 32'(bus.fact_go), 32'd1);
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_fact_n", bus.fact_n, 32'd5);
        tick();
        check("t1_go_lo", 32'(bus.fact_go), 32'd0);
        repeat (10) tick();
        rd_reg(FACT_STAT, v);
        check("t1_capture_stat", v, 32'h1);
        check("t1_capture_busy", 32'(busy), 32'd1);
        tick();
        check("t1_idle_busy", 32'(busy), 32'd0);
        check("t1_go_count", 32'(go_pulses - g0), 32'd1);
        rd_reg(FACT_RES, v);
        check("t1_result", v, 32'd120);

        // Error run, N=13, IE=1
        wr(FACT_STAT, 32'hF);
        wr(FACT_CTRL, 32'h2);
        acc_lat = 5;
        wr(FACT_N, 32'd13);
        wr(FACT_CTRL, 32'h3);
        rd_reg(FACT_STAT, v);
        for (int i = 0; i < 40 && v == 32'd0; i++) begin
            tick();
            rd_reg(FACT_STAT, v);
        end
        check("t2_status", v, 32'h2);
        check("t2_irq_before", 32'(irq), 32'd0);
        tick();
        check("t2_irq_after", 32'(irq), 32'd1);
        wait_idle(20);
        rd_reg(FACT_RES, v);
        check("t2_result_kept", v, 32'd120);

        // Timeout run, silent accelerator
        acc_silent = 1'b1;
        wr(FACT_N, 32'd1);
        wr(FACT_CTRL, 32'h1);
        repeat (16) tick();
        rd_reg(FACT_STAT, v);
        check("t3_no_tout_yet", v, 32'h0);
        check("t3_busy_wait", 32'(busy), 32'd1);
        tick();
        rd_reg(FACT_STAT, v);
        check("t3_tout", v, 32'h4);
        check("t3_busy_cap", 32'(busy), 32'd1);
        tick();
        check("t3_busy_idle", 32'(busy), 32'd0);
        acc_silent = 1'b0;

        // Overrun: GO and N write during WAIT
        acc_lat = 10;
        wr(FACT_N, 32'd5);
        g0 = go_pulses;
        wr(FACT_CTRL, 32'h1);
        repeat (3) tick();
        wr(FACT_CTRL, 32'h1);
        wr(FACT_N, 32'd7);
        check("t4_fact_n", bus.fact_n, 32'd5);
        rd_reg(FACT_N, v);
        check("t4_n_reg", v, 32'd7);
        wait_idle(40);
        rd_reg(FACT_STAT, v);
        check("t4_status", v, 32'h9);
        rd_reg(FACT_RES, v);
        check("t4_result", v, 32'd120);
        check("t4_go_count", 32'(go_pulses - g0), 32'd1);

        // Stale done level held into the new run
        acc_hold = 5; acc_lat = 4;
        wr(FACT_N, 32'd4);
        wr(FACT_CTRL, 32'h1);
        repeat (3) tick();
        rd_reg(FACT_STAT, v);
        check("t5_stale_ignored", v, 32'h8);
        check("t5_busy", 32'(busy), 32'd1);
        wait_idle(40);
        rd_reg(FACT_RES, v);
        check("t5_result", v, 32'd24);
        rd_reg(FACT_STAT, v);
        check("t5_status", v, 32'h9);

        // W1C of all bits on the same edge as the DONE set
        acc_hold = 0; acc_lat = 6;
        wr(FACT_N, 32'd3);
        wr(FACT_CTRL, 32'h1);
        repeat (6) tick();
        rd_reg(FACT_STAT, v);
        check("t6_pre_status", v, 32'h8);
        wr(FACT_STAT, 32'hF);
        rd_reg(FACT_STAT, v);
        check("t6_set_wins", v, 32'h1);
        wait_idle(10);
        rd_reg(FACT_RES, v);
        check("t6_result", v, 32'd6);
        exp_res = 32'd6;

        // Randomized runs against the expectation model
        for (int r = 0; r < 20; r++) begin
            int          n;
            int          ie;
            logic [31:0] exp_stat;
            n        = int'($urandom_range(0, 15));
            ie       = int'($urandom_range(0, 1));
            acc_lat  = int'($urandom_range(2, 12));
            acc_hold = int'($urandom_range(0, 3));
            wr(FACT_STAT, 32'hF);
            wr(FACT_N, 32'(n));
            g0 = go_pulses;
            wr(FACT_CTRL, (32'(ie) << 1) | 32'h1);
            if ($urandom_range(0, 1) == 1) begin
                tick();
                wr(FACT_N, $urandom);
            end
            check($sformatf("r%0d_fact_n", r), bus.fact_n, 32'(n));
            wait_idle(40);
            if (n <= 12) begin
                exp_stat = 32'h1;
                exp_res  = fact_ref(n);
            end else begin
                exp_stat = 32'h2;
            end
            rd_reg(FACT_STAT, v);
            check($sformatf("r%0d_status", r), v, exp_stat);
            rd_reg(FACT_RES, v);
            check($sformatf("r%0d_result", r), v, exp_res);
            check($sformatf("r%0d_irq", r), 32'(irq), 32'(ie));
            check($sformatf("r%0d_go_count", r), 32'(go_pulses - g0), 32'd1);
        end

        // Reset in the middle of WAIT
        acc_hold = 0; acc_lat = 10;
        wr(FACT_N, 32'd9);
        wr(FACT_CTRL, 32'h3);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        check("t7_go", 32'(bus.fact_go), 32'd0);
        check("t7_busy", 32'(busy), 32'd0);
        check("t7_irq", 32'(irq), 32'd0);
        check("t7_fact_n", bus.fact_n, 32'd0);
        for (int a = 0; a < 4; a++) begin
            rd_reg(2'(a), v);
            check($sformatf("t7_rd%0d", a), v, 32'd0);
        end
        rst = 1'b0;
        tick();
        acc_lat = 3;
        wr(FACT_N, 32'd2);
        wr(FACT_CTRL, 32'h1);
        check("t7_relaunch_busy", 32'(busy), 32'd1);
        wait_idle(30);
        rd_reg(FACT_STAT, v);
        check("t7_status", v, 32'h1);
        rd_reg(FACT_RES, v);
        check("t7_result", v, 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
